// File: rtl/vision_pkg.sv
// -----------------------------------------------------------------------------
// vision_pkg
// Shared types and helpers for the vision move controller.
//   state_t     : controller states, encoded as reported on state_out
//   row_t/col_t : 2-bit row and column indices of the 3x3 quadrant grid
//   LANE_*      : lane encodings driven on lane_out
//   quad_idx()  : bit position of quadrant (row, col) in the occupancy word
// -----------------------------------------------------------------------------
package vision_pkg;

   typedef logic [1:0] row_t;
   typedef logic [1:0] col_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CAL   = 2'd1,
      ST_TRACK = 2'd2,
      ST_LOST  = 2'd3
   } state_t;

   localparam col_t LANE_LEFT   = 2'd0;
   localparam col_t LANE_CENTRE = 2'd1;
   localparam col_t LANE_RIGHT  = 2'd2;

   function automatic logic [3:0] quad_idx(input row_t row, input col_t col);
      return ({2'b00, row} * 4'd3) + {2'b00, col};
   endfunction

endpackage

// File: rtl/vision_frame_features.sv
// -----------------------------------------------------------------------------
// vision_frame_features
// Purely combinational decode of one 3x3 occupancy word into frame features.
//   i_quadrants        : occupancy, bit 3*row+col, row 0 top, col 0 left
//   o_col_occ          : per-column OR over the three rows
//   o_cand_lane        : occupied column when exactly one column is occupied
//   o_cand_lane_valid  : exactly one column is occupied
//   o_top_row          : smallest row with any occupied bit
//   o_top_row_present  : at least one bit of i_quadrants is set
// -----------------------------------------------------------------------------
module vision_frame_features
   import vision_pkg::*;
(
   input  logic [8:0] i_quadrants,
   output logic [2:0] o_col_occ,
   output col_t       o_cand_lane,
   output logic       o_cand_lane_valid,
   output row_t       o_top_row,
   output logic       o_top_row_present
);

   always_comb begin
      o_col_occ = 3'b000;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (i_quadrants[quad_idx(row_t'(r), col_t'(c))]) begin
               o_col_occ[c] = 1'b1;
            end
         end
      end
   end

   // A lane candidate exists only when the player occupies a single column.
   always_comb begin
      o_cand_lane       = LANE_CENTRE;
      o_cand_lane_valid = 1'b0;
      case (o_col_occ)
         3'b001: begin o_cand_lane = LANE_LEFT;   o_cand_lane_valid = 1'b1; end
         3'b010: begin o_cand_lane = LANE_CENTRE; o_cand_lane_valid = 1'b1; end
         3'b100: begin o_cand_lane = LANE_RIGHT;  o_cand_lane_valid = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      o_top_row         = 2'd0;
      o_top_row_present = 1'b1;
      if (|i_quadrants[2:0]) begin
         o_top_row = 2'd0;
      end else if (|i_quadrants[5:3]) begin
         o_top_row = 2'd1;
      end else if (|i_quadrants[8:6]) begin
         o_top_row = 2'd2;
      end else begin
         o_top_row_present = 1'b0;
      end
   end

endmodule

// File: rtl/vision_move_controller.sv
// -----------------------------------------------------------------------------
// vision_move_controller
// Calibrate/track/lost controller turning per-frame quadrant occupancy into
// debounced lane-change and jump events for the game logic.
//   pixel_clock_in     : sole clock
//   rst_in             : synchronous active-high reset
//   calibrate_in       : one-cycle request to (re)start calibration
//   quadrants_in       : 3x3 occupancy word, valid with quadrants_valid_in
//   quadrants_valid_in : one-cycle frame strobe
//   move_valid_out     : event pending (valid/ready with move_ready_in)
//   move_ready_in      : consumer accepts the pending event
//   lane_out           : current lane (0 left, 1 centre, 2 right)
//   jump_out           : jump flag of the pending event
//   calibrated_out     : baseline row captured
//   signal_lost_out    : high while in LOST
//   state_out          : IDLE=0, CAL=1, TRACK=2, LOST=3
// -----------------------------------------------------------------------------
module vision_move_controller
   import vision_pkg::*;
#(
   parameter int unsigned STABLE_FRAMES  = 3,
   parameter int unsigned CAL_FRAMES     = 8,
   parameter logic [19:0] TIMEOUT_CYCLES = 20'd800000
) (
   input  logic       pixel_clock_in,
   input  logic       rst_in,
   input  logic       calibrate_in,
   input  logic [8:0] quadrants_in,
   input  logic       quadrants_valid_in,
   output logic       move_valid_out,
   input  logic       move_ready_in,
   output logic [1:0] lane_out,
   output logic       jump_out,
   output logic       calibrated_out,
   output logic       signal_lost_out,
   output logic [1:0] state_out
);

   localparam logic [3:0] LP_STABLE = 4'(STABLE_FRAMES);
   localparam logic [3:0] LP_CAL    = 4'(CAL_FRAMES);

   state_t      r_state;
   state_t      w_state_next;
   logic [3:0]  r_cal_cnt;
   row_t        r_prev_top;
   logic [3:0]  r_lane_cnt;
   col_t        r_prev_cand;
   logic        r_prev_cand_vld;
   logic [3:0]  r_jump_cnt;
   logic        r_jump_armed;
   row_t        r_baseline;
   col_t        r_lane;
   logic        r_jump;
   logic        r_valid;
   logic        r_calibrated;
   logic        r_lost;
   logic [19:0] r_to_cnt;

   logic [2:0]  w_col_occ;
   col_t        w_cand_lane;
   logic        w_cand_vld;
   row_t        w_top_row;
   logic        w_top_present;

   vision_frame_features u_features (
      .i_quadrants       (quadrants_in),
      .o_col_occ         (w_col_occ),
      .o_cand_lane       (w_cand_lane),
      .o_cand_lane_valid (w_cand_vld),
      .o_top_row         (w_top_row),
      .o_top_row_present (w_top_present)
   );

   // Calibration requests win over frames in the same cycle.
   logic        w_frame;
   logic        w_trk_frame;
   logic        w_occupied;
   logic [3:0]  w_cal_next;
   logic        w_cal_done;
   logic        w_lane_chg;
   logic [3:0]  w_lane_next;
   logic        w_lane_post;
   logic        w_high;
   logic [3:0]  w_jump_next;
   logic        w_jump_post;
   logic        w_post;
   logic        w_accept;
   logic [19:0] w_to_next;
   logic        w_to_hit;

   assign w_frame     = quadrants_valid_in && !calibrate_in;
   assign w_trk_frame = w_frame && (r_state == ST_TRACK);
   assign w_occupied  = |w_col_occ;

   // A zero cal_cnt means no usable previous top row to compare against.
   assign w_cal_next = (w_top_present && (r_cal_cnt != 4'd0) && (w_top_row == r_prev_top))
                       ? r_cal_cnt + 4'd1
                       : {3'b000, w_top_present};
   assign w_cal_done = w_frame && (r_state == ST_CAL) && (w_cal_next == LP_CAL);

   // Only a candidate that would move the player counts towards a lane change.
   assign w_lane_chg  = w_cand_vld && (w_cand_lane != r_lane);
   assign w_lane_next = (w_lane_chg && r_prev_cand_vld && (w_cand_lane == r_prev_cand))
                        ? r_lane_cnt + 4'd1
                        : {3'b000, w_lane_chg};
   assign w_lane_post = w_trk_frame && (w_lane_next == LP_STABLE);

   // While disarmed, high frames hold the jump count instead of advancing it.
   assign w_high      = w_top_present && (w_top_row < r_baseline);
   assign w_jump_next = !w_high      ? 4'd0 :
                        r_jump_armed ? r_jump_cnt + 4'd1 : r_jump_cnt;
   assign w_jump_post = w_trk_frame && w_high && r_jump_armed && (w_jump_next == LP_STABLE);

   assign w_post   = w_lane_post || w_jump_post;
   assign w_accept = r_valid && move_ready_in;

   assign w_to_next = quadrants_valid_in           ? 20'd0 :
                      (r_to_cnt == TIMEOUT_CYCLES) ? r_to_cnt : r_to_cnt + 20'd1;
   assign w_to_hit  = (w_to_next == TIMEOUT_CYCLES);

   always_ff @(posedge pixel_clock_in) begin
      if (rst_in) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (calibrate_in) begin
         w_state_next = ST_CAL;
      end else begin
         case (r_state)
            ST_IDLE:  w_state_next = ST_IDLE;
            ST_CAL: begin
               if (w_cal_done) begin
                  w_state_next = ST_TRACK;
               end else if (w_to_hit) begin
                  w_state_next = ST_LOST;
               end
            end
            ST_TRACK: begin
               if (w_to_hit) begin
                  w_state_next = ST_LOST;
               end
            end
            ST_LOST: begin
               if (quadrants_valid_in) begin
                  w_state_next = r_calibrated ? ST_TRACK : ST_CAL;
               end
            end
            default:  w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge pixel_clock_in) begin
      if (rst_in) begin
         r_cal_cnt       <= 4'd0;
         r_prev_top      <= 2'd0;
         r_lane_cnt      <= 4'd0;
         r_prev_cand     <= LANE_CENTRE;
         r_prev_cand_vld <= 1'b0;
         r_jump_cnt      <= 4'd0;
         r_jump_armed    <= 1'b0;
         r_baseline      <= 2'd2;
         r_lane          <= LANE_CENTRE;
         r_calibrated    <= 1'b0;
         r_lost          <= 1'b0;
         r_to_cnt        <= 20'd0;
      end else begin
         r_to_cnt <= w_to_next;
         if (calibrate_in) begin
            r_calibrated    <= 1'b0;
            r_lost          <= 1'b0;
            r_cal_cnt       <= 4'd0;
            r_lane_cnt      <= 4'd0;
            r_jump_cnt      <= 4'd0;
            r_prev_cand_vld <= 1'b0;
         end else begin
            case (r_state)
               ST_CAL: begin
                  if (quadrants_valid_in) begin
                     r_cal_cnt  <= w_cal_next;
                     r_prev_top <= w_top_row;
                     if (w_cal_done) begin
                        r_baseline   <= w_top_row;
                        r_calibrated <= 1'b1;
                     end
                  end else if (w_to_hit) begin
                     r_lost <= 1'b1;
                  end
               end
               ST_TRACK: begin
                  if (quadrants_valid_in) begin
                     r_lane_cnt      <= w_lane_post ? 4'd0 : w_lane_next;
                     r_prev_cand     <= w_cand_lane;
                     r_prev_cand_vld <= w_cand_vld;
                     if (w_lane_post) begin
                        r_lane <= w_cand_lane;
                     end
                     r_jump_cnt <= w_jump_post ? 4'd0 : w_jump_next;
                     if (w_jump_post) begin
                        r_jump_armed <= 1'b0;
                     end else if (w_occupied && !w_high) begin
                        r_jump_armed <= 1'b1;
                     end
                  end else if (w_to_hit) begin
                     r_lost <= 1'b1;
                  end
               end
               ST_LOST: begin
                  // The recovery frame only restarts tracking; it is not evaluated.
                  if (quadrants_valid_in) begin
                     r_lost          <= 1'b0;
                     r_cal_cnt       <= 4'd0;
                     r_lane_cnt      <= 4'd0;
                     r_jump_cnt      <= 4'd0;
                     r_prev_cand_vld <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Single-entry event register; an unaccepted event absorbs new posts.
   always_ff @(posedge pixel_clock_in) begin
      if (rst_in) begin
         r_valid <= 1'b0;
         r_jump  <= 1'b0;
      end else if (w_post) begin
         r_valid <= 1'b1;
         r_jump  <= (r_valid && !w_accept) ? (r_jump || w_jump_post) : w_jump_post;
      end else if (w_accept) begin
         r_valid <= 1'b0;
         r_jump  <= 1'b0;
      end
   end

   assign move_valid_out  = r_valid;
   assign lane_out        = r_lane;
   assign jump_out        = r_jump;
   assign calibrated_out  = r_calibrated;
   assign signal_lost_out = r_lost;
   assign state_out       = r_state;

endmodule

// File: tb/tb_vision_move_controller.sv
module tb_vision_move_controller;

   logic       clk = 1'b0;
   logic       rst_in = 1'b1;
   logic       calibrate_in = 1'b0;
   logic [8:0] quadrants_in = 9'd0;
   logic       quadrants_valid_in = 1'b0;
   logic       move_valid_out;
   logic       move_ready_in = 1'b0;
   logic [1:0] lane_out;
   logic       jump_out;
   logic       calibrated_out;
   logic       signal_lost_out;
   logic [1:0] state_out;

   int checks = 0;
   int errors = 0;
   logic [2:0] sb_q[$];   // expected {lane, jump} of each accepted event

   vision_move_controller #(
      .STABLE_FRAMES  (3),
      .CAL_FRAMES     (8),
      .TIMEOUT_CYCLES (20'd40)
   ) dut (
      .pixel_clock_in     (clk),
      .rst_in             (rst_in),
      .calibrate_in       (calibrate_in),
      .quadrants_in       (quadrants_in),
      .quadrants_valid_in (quadrants_valid_in),
      .move_valid_out     (move_valid_out),
      .move_ready_in      (move_ready_in),
      .lane_out           (lane_out),
      .jump_out           (jump_out),
      .calibrated_out     (calibrated_out),
      .signal_lost_out    (signal_lost_out),
      .state_out          (state_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [8:0] q);
      quadrants_in       = q;
      quadrants_valid_in = 1'b1;
      tick();
      quadrants_valid_in = 1'b0;
   endtask

   task automatic accept();
      move_ready_in = 1'b1;
      tick();
      move_ready_in = 1'b0;
   endtask

   task automatic push_exp(input logic [1:0] lane, input logic jump);
      sb_q.push_back({lane, jump});
   endtask

   // Monitor: every handshake must match the oldest expected event.
   always @(negedge clk) begin
      if (!rst_in && move_valid_out && move_ready_in) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got lane %0d jump %0d expected no event", lane_out, jump_out);
         end else begin
            logic [2:0] e;
            e = sb_q.pop_front();
            if ({lane_out, jump_out} !== e) begin
               errors++;
               $display("FAIL sb_event: got lane %0d jump %0d expected lane %0d jump %0d",
                        lane_out, jump_out, e[2:1], e[0]);
            end
         end
      end
   end

   initial begin
      int waited;
      repeat (3) tick();
      rst_in = 1'b0;
      tick();
      check("rst_state", state_out, 0);
      check("rst_lane", lane_out, 1);
      check("rst_jump", jump_out, 0);
      check("rst_valid", move_valid_out, 0);
      check("rst_cal", calibrated_out, 0);
      check("rst_lost", signal_lost_out, 0);

      frame(9'b100_000_000);
      check("idle_ignores_frame", state_out, 0);

      calibrate_in = 1'b1;
      tick();
      calibrate_in = 1'b0;
      check("cal_state", state_out, 1);
      repeat (7) frame(9'b100_000_000);
      check("cal_not_done_7", calibrated_out, 0);
      frame(9'b100_000_000);
      check("cal_done", calibrated_out, 1);
      check("cal_track", state_out, 2);

      // Lane change to left.
      repeat (2) frame(9'b001_001_000);
      check("lane_early", move_valid_out, 0);
      push_exp(2'd0, 1'b0);
      frame(9'b001_001_000);
      check("lane_valid", move_valid_out, 1);
      check("lane_left", lane_out, 0);
      check("lane_nojump", jump_out, 0);
      accept();
      check("lane_acc", move_valid_out, 0);

      // Two-frame burst then a different column: no event.
      repeat (2) frame(9'b100_000_000);
      frame(9'b010_000_000);
      check("burst_none", move_valid_out, 0);
      check("burst_lane", lane_out, 0);
      push_exp(2'd1, 1'b0);
      repeat (2) frame(9'b010_000_000);
      check("back_centre", lane_out, 1);
      accept();

      // Jump, then held-high frames must not repeat it.
      push_exp(2'd1, 1'b1);
      repeat (3) frame(9'b000_000_010);
      check("jump_valid", move_valid_out, 1);
      check("jump_flag", jump_out, 1);
      accept();
      check("jump_acc_valid", move_valid_out, 0);
      check("jump_acc_flag", jump_out, 0);
      repeat (3) frame(9'b000_000_010);
      check("jump_no_repeat", move_valid_out, 0);
      frame(9'b010_000_000);
      repeat (3) frame(9'b000_000_010);
      check("jump2_valid", move_valid_out, 1);
      check("jump2_flag", jump_out, 1);

      // Lane event merges into the pending jump event.
      push_exp(2'd2, 1'b1);
      repeat (3) frame(9'b100_000_000);
      check("merge_valid", move_valid_out, 1);
      check("merge_lane", lane_out, 2);
      check("merge_jump", jump_out, 1);
      accept();
      check("merge_acc", move_valid_out, 0);

      // Timeout into LOST and recovery.
      waited = 0;
      while (!signal_lost_out && waited < 100) begin
         tick();
         waited++;
      end
      check("lost_flag", signal_lost_out, 1);
      check("lost_state", state_out, 3);
      frame(9'b001_000_000);
      check("recover_state", state_out, 2);
      check("recover_lost", signal_lost_out, 0);
      repeat (2) frame(9'b001_000_000);
      check("recover_not_counted", move_valid_out, 0);
      push_exp(2'd0, 1'b0);
      frame(9'b001_000_000);
      check("recover_event", move_valid_out, 1);
      check("recover_lane", lane_out, 0);

      // Calibrate with a simultaneous frame; pending event survives.
      calibrate_in       = 1'b1;
      quadrants_in       = 9'b100_000_000;
      quadrants_valid_in = 1'b1;
      tick();
      calibrate_in       = 1'b0;
      quadrants_valid_in = 1'b0;
      check("recal_state", state_out, 1);
      check("recal_cal", calibrated_out, 0);
      check("recal_pending", move_valid_out, 1);
      repeat (7) frame(9'b100_000_000);
      check("recal_frame_ignored", state_out, 1);
      frame(9'b100_000_000);
      check("recal_done_state", state_out, 2);
      check("recal_done_cal", calibrated_out, 1);
      accept();
      check("final_acc", move_valid_out, 0);

      repeat (2) tick();
      check("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
